// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, frame
// classes and key-map decoding used by keypad_scan and keypad_debounce.
package keypad_pkg;

    localparam int CODE_W = 4;
    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;
    localparam int N_KEYS = N_ROWS * N_COLS;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_class_e;

    function automatic frame_class_e classify(input logic [N_KEYS-1:0] map);
        logic [4:0] ones;
        ones = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            ones = ones + 5'(map[i]);
        end
        if (ones == 5'd0) begin
            return FR_NONE;
        end
        if (ones == 5'd1) begin
            return FR_SINGLE;
        end
        return FR_MULTI;
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [CODE_W-1:0] key_code(input logic [N_KEYS-1:0] map);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (map[i]) begin
                code = CODE_W'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM and output registers for keypad_scan.
// Auto-repeat strobes are built only when KEYPAD_REPEAT_EN is defined.
//
// state       | meaning
// ------------+-----------------------------------------------------
// ST_IDLE     | no key accepted, waiting for a single-key frame
// ST_DEBOUNCE | candidate key seen, counting identical frames
// ST_PRESSED  | key accepted and held
// ST_RELEASE  | empty frames seen, counting toward release
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEB_FRAMES    = 4,
    parameter int REPEAT_FRAMES = 250
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              frame_i,
    input  logic [1:0]        class_i,
    input  logic [CODE_W-1:0] code_i,
    output logic [CODE_W-1:0] key_o,
    output logic              key_valid_o,
    output logic              key_held_o
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES);

    kp_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] key_q, key_d;
    logic              valid_q, valid_d;
    logic              accept;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES);

    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] rep_nxt;
    logic             stay_pressed;

    assign rep_nxt      = rep_q + REP_W'(1);
    assign stay_pressed = frame_i && (state_q == ST_PRESSED) && (class_i != FR_NONE);
`else
    // Repeat spacing has no effect when auto-repeat is not built.
    localparam int unused_repeat_frames = REPEAT_FRAMES;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        key_d   = key_q;
        accept  = 1'b0;
        if (frame_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (class_i == FR_SINGLE) begin
                        cand_d = code_i;
                        cnt_d  = 4'd1;
                        if (DEB_LAST == 4'd1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if ((class_i == FR_SINGLE) && (code_i == cand_q)) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB_LAST) begin
                            accept = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    // Multi-key or a different single key both count as still pressed.
                    if (class_i == FR_NONE) begin
                        cnt_d   = 4'd1;
                        state_d = (DEB_LAST == 4'd1) ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (class_i == FR_NONE) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (accept) begin
            state_d = ST_PRESSED;
            key_d   = cand_d;
        end
        valid_d = accept;
`ifdef KEYPAD_REPEAT_EN
        rep_d = rep_q;
        if (accept) begin
            rep_d = '0;
        end else if (stay_pressed) begin
            if (rep_nxt == REP_LAST) begin
                rep_d   = '0;
                valid_d = 1'b1;
            end else begin
                rep_d = rep_nxt;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            key_q   <= key_d;
            valid_q <= valid_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign key_o       = key_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);

endmodule

// File: rtl/prescaler.sv
// Modulo-N clock-enable prescaler: tick_o pulses for one CE-qualified cycle
// every MODULO enabled cycles.
module prescaler #(
    parameter int MODULO = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ce_i,
    output logic tick_o
);

    localparam int CNT_W = (MODULO > 1) ? $clog2(MODULO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MODULO - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = ce_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (ce_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column drive, row synchronizer, key-map capture and
// frame classification. Auto-repeat is enabled with KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter int DEB_FRAMES    = 4,
    parameter int REPEAT_FRAMES = 250
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ce_i,
    input  logic [3:0]  row_in_i,
    output logic [3:0]  col_out_o,
    output logic [3:0]  key_o,
    output logic        key_valid_o,
    output logic        key_held_o
);

    logic [N_ROWS-1:0] row_s1_q, row_s2_q;
    logic              tick;
    logic [1:0]        col_q, col_d;
    logic [N_KEYS-1:0] map_q, map_d;
    logic              frame_end;
    logic [1:0]        frame_cls;
    logic [CODE_W-1:0] frame_code;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            row_s1_q <= '1;
            row_s2_q <= '1;
        end else begin
            row_s1_q <= row_in_i;
            row_s2_q <= row_s1_q;
        end
    end

    prescaler #(
        .MODULO (SCAN_DIV)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ce_i    (ce_i),
        .tick_o  (tick)
    );

    // Rows are sampled just before the column moves on, so each column has
    // a full tick period to settle. Bit index is row*4+col, active-high.
    always_comb begin
        col_d = col_q;
        map_d = map_q;
        if (tick) begin
            col_d = col_q + 2'd1;
            for (int r = 0; r < N_ROWS; r++) begin
                map_d[{2'(r), col_q}] = ~row_s2_q[r];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_q <= '0;
            map_q <= '0;
        end else begin
            col_q <= col_d;
            map_q <= map_d;
        end
    end

    assign col_out_o = ~(4'b0001 << col_q);

    // Classify the map including the column captured on this very tick.
    assign frame_end  = tick && (col_q == 2'd3);
    assign frame_cls  = classify(map_d);
    assign frame_code = key_code(map_d);

    keypad_debounce #(
        .DEB_FRAMES    (DEB_FRAMES),
        .REPEAT_FRAMES (REPEAT_FRAMES)
    ) u_debounce (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .frame_i     (frame_end),
        .class_i     (frame_cls),
        .code_i      (frame_code),
        .key_o       (key_o),
        .key_valid_o (key_valid_o),
        .key_held_o  (key_held_o)
    );

endmodule
